lsu_byte_sequencer: RTL and testbench

Load/store sequencer between the EX/MEM pipeline register and a byte-wide, synchronous-read data memory. Accepts one load or store (lb/lh/lw/lbu/lhu, sb/sh/sw by funct3) and performs it as 1, 2 or 4 consecutive byte accesses. While it works, it stalls the pipeline. On completion it returns the assembled, sign- or zero-extended load value. It also flags illegal funct3, conflicting read/write requests and out-of-range addresses.

---
 rtl/lsu_byte_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer between EX/MEM and a byte-wide synchronous-read memory.
// Each request becomes 1, 2 or 4 consecutive byte accesses; the pipeline is stalled until done.
module lsu_byte_sequencer #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        inst,
  input  logic [31:0]       addr,
  input  logic [31:0]       WriteData,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       ReadData,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

  state_t              state_reg;
  logic [2:0]          k_reg;
  logic [2:0]          n_reg;
  logic                is_load_reg;
  logic [2:0]          f3_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [31:0]         wd_reg;
  logic [31:0]         assy_reg;
  logic                done_reg;
  logic                err_reg;
  logic [31:0]         rdata_reg;
  logic                mem_en_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [7:0]          mem_wdata_reg;

  logic                req;
  logic [2:0]          req_n;
  logic                legal;
  logic [32:0]         last_addr;
  logic                oob;
  logic                req_err;
  logic [2:0]          k_inc;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [7:0]          nxt_byte;
  logic [31:0]         cap;
  logic [31:0]         ext;

  assign req = MemRead | MemWrite;

  always_comb begin
    req_n = 3'd0;
    case (inst)
      3'b000, 3'b100: req_n = 3'd1;
      3'b001, 3'b101: req_n = 3'd2;
      3'b010:         req_n = 3'd4;
      default:        req_n = 3'd0;
    endcase
  end

  // Unsigned variants (inst[2]=1) exist only for loads.
  always_comb begin
    legal = 1'b0;
    if (MemRead && !MemWrite)
      legal = (req_n != 3'd0);
    else if (MemWrite && !MemRead)
      legal = (req_n != 3'd0) && !inst[2];
  end

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign last_addr = {1'b0, addr} + 33'(req_n) - 33'd1;
  assign oob       = last_addr >= 33'(DEPTH);
  assign req_err   = !legal || oob;

  assign k_inc    = k_reg + 3'd1;
  assign nxt_addr = base_reg + ADDR_W'(k_inc);
  assign nxt_byte = 8'(wd_reg >> {k_inc, 3'b000});

  // The byte returned this cycle belongs to lane k-1 (issued one cycle earlier).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign cap[8*gi +: 8] = (k_reg == 3'(gi + 1)) ? mem_rdata : assy_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    ext = cap;
    case (f3_reg)
      3'b000:  ext = {{24{cap[7]}}, cap[7:0]};
      3'b001:  ext = {{16{cap[15]}}, cap[15:0]};
      3'b100:  ext = {24'd0, cap[7:0]};
      3'b101:  ext = {16'd0, cap[15:0]};
      default: ext = cap;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      k_reg         <= 3'd0;
      n_reg         <= 3'd0;
      is_load_reg   <= 1'b0;
      f3_reg        <= 3'd0;
      base_reg      <= '0;
      wd_reg        <= 32'd0;
      assy_reg      <= 32'd0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rdata_reg     <= 32'd0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            f3_reg      <= inst;
            is_load_reg <= MemRead & ~MemWrite;
            n_reg       <= req_n;
            base_reg    <= addr[ADDR_W-1:0];
            wd_reg      <= WriteData;
            k_reg       <= 3'd0;
            assy_reg    <= 32'd0;
            if (req_err) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end else begin
              // First byte is presented in the very next cycle.
              state_reg     <= ACCESS;
              mem_en_reg    <= 1'b1;
              mem_we_reg    <= MemWrite;
              mem_addr_reg  <= addr[ADDR_W-1:0];
              mem_wdata_reg <= MemWrite ? WriteData[7:0] : 8'd0;
            end
          end
        end
        ACCESS: begin
          if (k_reg != 3'd0)
            assy_reg <= cap;
          k_reg <= k_inc;
          if (k_inc == n_reg) begin
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 8'd0;
            if (is_load_reg) begin
              state_reg <= DRAIN;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end else begin
            mem_addr_reg  <= nxt_addr;
            mem_wdata_reg <= is_load_reg ? 8'd0 : nxt_byte;
          end
        end
        DRAIN: begin
          assy_reg  <= cap;
          rdata_reg <= ext;
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= 32'd0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stall     = rst_n & (((state_reg == IDLE) & req) | (state_reg == ACCESS) | (state_reg == DRAIN));
  assign done      = done_reg;
  assign err       = err_reg;
  assign ReadData  = rdata_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Randomized scoreboard bench for lsu_byte_sequencer with a byte-array memory and reference model.
module tb_lsu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  inst = 3'd0;
  logic [31:0] addr = 32'd0, WriteData = 32'd0;
  logic        stall, done, err, mem_en, mem_we;
  logic [31:0] ReadData;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  lsu_byte_sequencer #(.DEPTH(128), .ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .inst(inst),
    .addr(addr), .WriteData(WriteData), .stall(stall), .done(done), .err(err),
    .ReadData(ReadData), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic logic [7:0] init_byte(int i);
    case (i)
      16: return 8'h78;
      17: return 8'h56;
      18: return 8'h34;
      19: return 8'h92;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  // Memory attached to the DUT: synchronous read, one cycle latency.
  logic [7:0] tb_mem [0:127];
  initial begin
    for (int i = 0; i < 128; i++) tb_mem[i] = init_byte(i);
    mem_rdata = 8'd0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        else        mem_rdata <= tb_mem[mem_addr];
      end
    end
  end

  typedef struct {
    int          start;
    int          lat;
    bit          err;
    logic [31:0] rdata;
    int          n;
    logic [31:0] base;
    bit          wr;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] ref_mem [0:127];

  function automatic exp_t model(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int n;
    bit ok;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      3'b010:         n = 4;
      default:        n = 0;
    endcase
    ok = (rd != wr) && (n != 0) && !(wr && f3[2]);
    if (ok && (longint'(a) + longint'(n) - 1 >= 128)) ok = 0;
    e.err = !ok;
    e.base = a;
    e.wr = ok && wr;
    e.wd = wd;
    e.n = ok ? n : 0;
    e.lat = !ok ? 1 : (rd ? n + 2 : n + 1);
    e.rdata = 32'd0;
    if (ok && wr)
      for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
    if (ok && rd) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
      case (f3)
        3'b000:  e.rdata = {{24{v[7]}}, v[7:0]};
        3'b001:  e.rdata = {{16{v[15]}}, v[15:0]};
        3'b100:  e.rdata = {24'd0, v[7:0]};
        3'b101:  e.rdata = {16'd0, v[15:0]};
        default: e.rdata = v;
      endcase
    end
    return e;
  endfunction

  // Monitor: checks stall and memory strobes each cycle, pops on done.
  exp_t        me;
  int          acc = 0;
  int          el;
  logic [31:0] ea, ws;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc = 0;
    end else if (exp_q.size() != 0) begin
      me = exp_q[0];
      el = cyc - me.start;
      chk("stall", {31'd0, stall}, {31'd0, (el < me.lat)});
      if (mem_en) begin
        ea = me.base + acc;
        chk("mem_addr", {25'd0, mem_addr}, {25'd0, ea[6:0]});
        chk("mem_we", {31'd0, mem_we}, {31'd0, me.wr});
        if (me.wr) begin
          ws = me.wd >> (8 * acc);
          chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, ws[7:0]});
        end
        acc++;
      end
      if (done) begin
        chk("latency", el, me.lat);
        chk("err", {31'd0, err}, {31'd0, me.err});
        chk("ReadData", ReadData, me.rdata);
        chk("access_count", acc, me.n);
        $display("txn base=%h wr=%0d err=%0d rdata=%h lat=%0d", me.base, me.wr, err, ReadData, el);
        void'(exp_q.pop_front());
        acc = 0;
      end
    end else begin
      chk("idle_quiet", {29'd0, done, mem_en, stall}, 32'd0);
    end
  end

  task automatic do_op(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int t;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; inst = f3; addr = a; WriteData = wd;
    e = model(rd, wr, f3, a, wd);
    e.start = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    // Garbage on the inputs after acceptance must be ignored.
    MemRead = 1'b0; MemWrite = 1'b0;
    inst = 3'($urandom); addr = $urandom; WriteData = $urandom;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no done for addr %h within 20 cycles", a);
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t e;
    int r;
    bit rd, wr;
    logic [31:0] a;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_byte(i);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_done", {30'd0, done, err}, 32'd0);
    chk("reset_ReadData", ReadData, 32'd0);
    chk("reset_mem", {16'd0, mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
    rst_n = 1'b1;

    do_op(1, 0, 3'b010, 32'h10, 0);
    do_op(1, 0, 3'b000, 32'h13, 0);
    do_op(1, 0, 3'b100, 32'h13, 0);
    do_op(1, 0, 3'b001, 32'h12, 0);
    do_op(1, 0, 3'b101, 32'h12, 0);
    do_op(0, 1, 3'b010, 32'h21, 32'hDEADBEEF);
    do_op(0, 1, 3'b000, 32'h21, 32'h000000AB);
    do_op(1, 0, 3'b010, 32'h21, 0);
    do_op(1, 0, 3'b010, 32'h7E, 0);
    do_op(0, 1, 3'b100, 32'h40, 32'h12345678);
    do_op(1, 1, 3'b010, 32'h40, 32'h12345678);
    do_op(1, 0, 3'b011, 32'h40, 0);
    do_op(1, 0, 3'b010, 32'h7C, 0);
    do_op(1, 0, 3'b010, 32'hFFFF_FFFE, 0);
    do_op(1, 0, 3'b010, 32'h8000_007C, 0);

    // Reset in the middle of a word store: two bytes land, the rest never do.
    @(posedge clk); #1;
    MemWrite = 1'b1; inst = 3'b010; addr = 32'h30; WriteData = 32'hCAFEF00D;
    e = model(0, 0, 3'b010, 32'h30, 32'hCAFEF00D);
    e.start = cyc; e.lat = 5; e.err = 0; e.wr = 1; e.n = 4; e.wd = 32'hCAFEF00D;
    exp_q.push_back(e);
    @(posedge clk); #1;
    MemWrite = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_stall", {31'd0, stall}, 32'd0);
    chk("midreset_done", {30'd0, done, err}, 32'd0);
    chk("midreset_ReadData", ReadData, 32'd0);
    chk("midreset_mem", {16'd0, mem_en, mem_we, mem_addr, mem_wdata}, 32'd0);
    exp_q.delete();
    ref_mem[8'h30] = 8'h0D;
    ref_mem[8'h31] = 8'hF0;
    @(posedge clk); #1 rst_n = 1'b1;
    do_op(1, 0, 3'b010, 32'h30, 0);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      rd = (r == 0) || (r < 5);
      wr = (r == 0) || (r >= 5);
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      do_op(rd, wr, 3'($urandom_range(0, 7)), a, $urandom);
    end

    repeat (2) @(posedge clk);
    for (int i = 0; i < 128; i++) chk("mem_contents", {24'd0, tb_mem[i]}, {24'd0, ref_mem[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
